// File: rtl/bus_width_pkg.sv
// Shared helpers for bus-width conversion blocks: ID width, beat count, FSM states.
package bus_width_pkg;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int beats(input int size_in, input int size_out);
    return size_out / size_in;
  endfunction

  typedef enum logic [1:0] {IDLE, PACK, HOLD} state_e;

endpackage

// File: rtl/packing_arbiter_if.sv
// Narrow request side plus wide packed output side of the packing arbiter.
interface packing_arbiter_if
  import bus_width_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = 32,
  localparam int ID_W    = id_w(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]         in_valid;
  logic [NUM_REQ-1:0]         in_ready;
  logic [NUM_REQ*SIZE_IN-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [SIZE_OUT-1:0]        out_data;
  logic [ID_W-1:0]            out_id;

  // Arbiter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id
  );

  // Producers/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search starting one past the last grant, with wrap.
module rr_arbiter
  import bus_width_pkg::*;
#(
  parameter int N     = 4,
  localparam int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_req
);
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt_id  = last;
    any_req = |req;
    for (int off = N; off >= 1; off--) begin
      idx = ID_W'((int'(last) + off) % N);
      if (req[idx]) gnt_id = idx;
    end
  end
endmodule

// File: rtl/packing_arbiter.sv
// Grants one narrow requester at a time and packs BEATS beats into one tagged wide word.
module packing_arbiter
  import bus_width_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SIZE_IN       = 8,
  parameter int SIZE_OUT      = 32,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  packing_arbiter_if.slave  bus,
  output logic              busy
);
  localparam int ID_W  = id_w(NUM_REQ);
  localparam int BEATS = beats(SIZE_IN, SIZE_OUT);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (SIZE_OUT % SIZE_IN != 0) begin : g_bad_width
    $error("packing_arbiter: SIZE_OUT must be a multiple of SIZE_IN");
  end
  if (NUM_REQ < 2) begin : g_bad_nreq
    $error("packing_arbiter: NUM_REQ must be >= 2");
  end

  state_e                          state_q, state_d;
  logic [ID_W-1:0]                 grant_q, grant_d, last_q, last_d;
  logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;
  logic [BEATS-1:0][SIZE_IN-1:0]   pack_q, pack_d;
  logic                            out_valid_q;
  logic [SIZE_OUT-1:0]             out_data_q;
  logic [ID_W-1:0]                 out_id_q;
  logic                            load;
  logic [SIZE_IN-1:0]              beat_in [NUM_REQ];
  logic [ID_W-1:0]                 arb_gnt;
  logic                            arb_any;
  logic                            out_free, beat_fire, last_beat;
  logic [CNT_W-1:0]                lane;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign beat_in[i] = bus.in_data[i*SIZE_IN +: SIZE_IN];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (bus.in_valid),
    .last    (last_q),
    .gnt_id  (arb_gnt),
    .any_req (arb_any)
  );

  assign out_free  = !out_valid_q || bus.out_ready;
  assign beat_fire = (state_q == PACK) && bus.in_valid[grant_q];
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS-1));
  assign lane      = LITTLE_ENDIAN ? beat_cnt_q : CNT_W'(BEATS-1) - beat_cnt_q;

  // Ready only toward the granted requester while packing.
  always_comb begin
    bus.in_ready = '0;
    if (state_q == PACK) bus.in_ready[grant_q] = 1'b1;
  end

  // Next state: arbitration, lane fill, output load decision.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    pack_d     = pack_q;
    load       = 1'b0;
    case (state_q)
      IDLE: if (arb_any) begin
        grant_d = arb_gnt;
        last_d  = arb_gnt;
        state_d = PACK;
      end
      PACK: if (beat_fire) begin
        pack_d[lane] = beat_in[grant_q];
        if (last_beat) begin
          if (out_free) begin
            load       = 1'b1;
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      HOLD: if (out_free) begin
        load       = 1'b1;
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pack buffer registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= ID_W'(NUM_REQ-1);
      beat_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      pack_q     <= pack_d;
    end
  end

  // Output slot: load wins over a same-cycle drain, otherwise hold until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= pack_d;
      out_id_q    <= grant_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign busy          = (state_q != IDLE) || out_valid_q;
endmodule

// File: tb/tb_packing_arbiter.sv
// Directed bench: table-driven single-requester word plus hand sequences for corners.
module tb_packing_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic busy, busy_be;
  int   n_cmp = 0;
  int   n_fail = 0;

  packing_arbiter_if #(.NUM_REQ(4), .SIZE_IN(8), .SIZE_OUT(32)) bus ();
  packing_arbiter_if #(.NUM_REQ(4), .SIZE_IN(8), .SIZE_OUT(32)) bus_be ();

  packing_arbiter #(.NUM_REQ(4), .SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  packing_arbiter #(.NUM_REQ(4), .SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .rst_n(rst_n), .bus(bus_be), .busy(busy_be));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got timeout, need $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;   // before the edge
    logic        exp_ov;    // after the edge
    logic [31:0] exp_od;
    logic [1:0]  exp_id;
    logic        exp_busy;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus_be.in_valid = '0; bus_be.in_data = '0; bus_be.out_ready = 1'b0;
    step(); step();
    chk("rst in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int ids[$];
    int cyc[$];
    logic [31:0] held;

    tv[0] = '{4'b0100, 32'h0011_0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b1};
    tv[1] = '{4'b0100, 32'h0011_0000, 1'b1, 4'b0100, 1'b0, 32'h0, 2'd0, 1'b1};
    tv[2] = '{4'b0100, 32'h0022_0000, 1'b1, 4'b0100, 1'b0, 32'h0, 2'd0, 1'b1};
    tv[3] = '{4'b0100, 32'h0033_0000, 1'b1, 4'b0100, 1'b0, 32'h0, 2'd0, 1'b1};
    tv[4] = '{4'b0100, 32'h0044_0000, 1'b1, 4'b0100, 1'b1, 32'h4433_2211, 2'd2, 1'b1};
    tv[5] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0};

    // Single requester, table driven
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = tv[i].vld; bus.in_data = tv[i].data; bus.out_ready = tv[i].ordy;
      #1;
      chk($sformatf("t%0d in_ready", i), 32'(bus.in_ready), 32'(tv[i].exp_rdy));
      step();
      chk($sformatf("t%0d out_valid", i), 32'(bus.out_valid), 32'(tv[i].exp_ov));
      chk($sformatf("t%0d busy", i), 32'(busy), 32'(tv[i].exp_busy));
      if (tv[i].exp_ov) begin
        chk($sformatf("t%0d out_data", i), bus.out_data, tv[i].exp_od);
        chk($sformatf("t%0d out_id", i), 32'(bus.out_id), 32'(tv[i].exp_id));
      end
    end

    // Round robin, all valid, one word every 5 cycles
    do_reset();
    bus.in_valid = 4'b1111; bus.in_data = 32'hA3A2_A1A0; bus.out_ready = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (bus.out_valid) begin
        ids.push_back(int'(bus.out_id)); cyc.push_back(c);
        chk("rr out_data", bus.out_data, {4{8'hA0 + 8'(bus.out_id)}});
      end
    end
    chk("rr word count", 32'(ids.size()), 32'd6);
    for (int k = 0; k < ids.size() && k < 6; k++) begin
      chk($sformatf("rr id%0d", k), 32'(ids[k]), 32'(k % 4));
      chk($sformatf("rr cycle%0d", k), 32'(cyc[k]), 32'(5 * (k + 1)));
    end

    // Backpressure: word 0 pending, word 1 parked in HOLD
    do_reset();
    bus.in_valid = 4'b0011; bus.in_data = 32'h0000_B1B0; bus.out_ready = 1'b0;
    repeat (10) step();
    chk("bp busy", 32'(busy), 32'h1);
    chk("bp out_valid", 32'(bus.out_valid), 32'h1);
    chk("bp out_data0", bus.out_data, 32'hB0B0_B0B0);
    chk("bp out_id0", 32'(bus.out_id), 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("bp hold in_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("bp hold data", bus.out_data, 32'hB0B0_B0B0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp out_valid1", 32'(bus.out_valid), 32'h1);
    chk("bp out_data1", bus.out_data, 32'hB1B1_B1B1);
    chk("bp out_id1", 32'(bus.out_id), 32'h1);
    held = bus.out_data;
    step();
    chk("bp word1 stable", bus.out_data, 32'hB1B1_B1B1);

    // Mid-word gap: grant stays on req3
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1000; bus.in_data = 32'h3100_0000;
    step(); step();
    bus.in_data = 32'h3200_0000;
    step();
    bus.in_valid = 4'b0001; bus.in_data = 32'h0000_00EE;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("gap in_ready", 32'(bus.in_ready), 32'h8);
      step();
    end
    bus.in_valid = 4'b1000; bus.in_data = 32'h3300_0000;
    step();
    bus.in_data = 32'h3400_0000;
    step();
    chk("gap out_valid", 32'(bus.out_valid), 32'h1);
    chk("gap out_data", bus.out_data, 32'h3433_3231);
    chk("gap out_id", 32'(bus.out_id), 32'h3);

    // Reset mid-word, then fresh word from req0
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0010; bus.in_data = 32'h0000_5100;
    step(); step();
    bus.in_data = 32'h0000_5200;
    step();
    rst_n = 1'b0;
    step();
    chk("mid-rst in_ready", 32'(bus.in_ready), 32'h0);
    chk("mid-rst out_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
    bus.in_valid = 4'b1111; bus.in_data = 32'h5352_51C1;
    step(); step();
    bus.in_data = 32'h5352_51C2; step();
    bus.in_data = 32'h5352_51C3; step();
    bus.in_data = 32'h5352_51C4; step();
    chk("post-rst out_valid", 32'(bus.out_valid), 32'h1);
    chk("post-rst out_id", 32'(bus.out_id), 32'h0);
    chk("post-rst out_data", bus.out_data, 32'hC4C3_C2C1);

    // Big-endian lane order on the second instance
    do_reset();
    bus_be.out_ready = 1'b1;
    bus_be.in_valid = 4'b0001; bus_be.in_data = 32'h0000_00AA;
    step(); step();
    bus_be.in_data = 32'h0000_00BB; step();
    bus_be.in_data = 32'h0000_00CC; step();
    bus_be.in_data = 32'h0000_00DD; step();
    chk("be out_valid", 32'(bus_be.out_valid), 32'h1);
    chk("be out_data", bus_be.out_data, 32'hAABB_CCDD);
    chk("be out_id", 32'(bus_be.out_id), 32'h0);
    chk("be busy", 32'(busy_be), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/packing_arbiter.md
Name: packing_arbiter

Overview:
- Shares one wide output bus between NUM_REQ narrow-bus requesters.
- Grants one requester at a time and packs SIZE_OUT/SIZE_IN consecutive beats from it into a single wide word.
- Tags each word with the source ID and rotates grants round-robin on word boundaries.
- Sits in front of wide-bus consumers (FIFOs, DMA write ports) that several narrow producers feed.

Parameters:
- NUM_REQ, 4: number of requesters, must be ≥2.
- SIZE_IN, 8: narrow beat width in bits.
- SIZE_OUT, 32: wide word width. Must be a multiple of SIZE_IN; elaboration-time error otherwise.
- LITTLE_ENDIAN, 1: 1 = first beat fills the LSB lane; 0 = first beat fills the MSB lane.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  NUM_REQ  per-requester beat valid.
- in_ready  out  NUM_REQ  per-requester beat ready; one-hot or zero.
- in_data  in  NUM_REQ*SIZE_IN  flattened beats; requester i occupies bits [i*SIZE_IN +: SIZE_IN].
- out_valid  out  1  wide word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  SIZE_OUT  packed word.
- out_id  out  ID_W  index of the requester that produced out_data.
- busy  out  1  high whenever the FSM is not IDLE or out_valid is high.

Behaviour:
- Definitions: BEATS = SIZE_OUT/SIZE_IN. ID_W = max(1, $clog2(NUM_REQ)). A transfer is valid&&ready in the same cycle.
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE; beat_cnt=0.
  - in_ready=0, out_valid=0, busy=0. out_data and out_id are don't-care.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - A partially packed word is discarded; an unaccepted out word is dropped.
- IDLE:
  - in_ready all 0.
  - If any in_valid is high, pick the first requester searching from last_grant+1 upward with wrap.
  - Register it as grant, set last_grant=grant, go to PACK.
  - Arbitration costs one cycle; no beat is accepted in IDLE.
- PACK:
  - in_ready[grant]=1 and all others 0, except when the FSM is in HOLD.
  - Each accepted beat writes lane beat_cnt (LITTLE_ENDIAN=1) or lane BEATS-1-beat_cnt (LITTLE_ENDIAN=0), then beat_cnt increments.
  - The grant is held until BEATS beats arrive, however long in_valid[grant] stays low. There is no timeout and no preemption.
  - Other requesters' in_valid are ignored.
- On the last beat (beat_cnt==BEATS-1):
  - If the output slot is free (!out_valid || out_ready in that same cycle), load out_data/out_id at that edge, set out_valid=1, beat_cnt=0, go to IDLE.
  - Otherwise go to HOLD with the packed word kept in the pack buffer.
  - Latency: last beat accepted at edge t, out_valid=1 from t+1.
- HOLD:
  - in_ready all 0.
  - When !out_valid || out_ready, load the output register, beat_cnt=0, go to IDLE.
  - A simultaneous out_ready and load keeps out_valid=1 with the new word.
- Output register:
  - out_valid, out_data and out_id stay stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new load happens in the same cycle.
- Throughput: BEATS+1 cycles per word per grant when out_ready stays high (one arbitration cycle plus BEATS beats).
- Fairness: with all requesters continuously valid, grants go 0,1,2,…,NUM_REQ-1,0,… with no repeat until every other valid requester is served.

Decomposition:
- Package bus_width_pkg holds:
  - a function computing ID_W;
  - the FSM state enum {IDLE, PACK, HOLD};
  - the BEATS helper for reuse by the other bus-width blocks.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], last[ID_W]; outputs gnt_id and any_req;
  - purely combinational round-robin search, instantiated once.

Test Plan:
- Reset then single requester: NUM_REQ=4, SIZE_IN=8, SIZE_OUT=32, LE=1. Req2 sends 0x11,0x22,0x33,0x44 back-to-back → out_data=0x44332211, out_id=2, out_valid one cycle after the 4th beat, in_ready[2] high only in PACK.
- Big-endian lane order: LE=0, req0 sends 0xAA,0xBB,0xCC,0xDD → out_data=0xAABBCCDD, out_id=0.
- Round-robin: all four requesters continuously valid, out_ready=1 → out_id sequence 0,1,2,3,0,1 and one word per 5 cycles.
- Backpressure: out_ready=0 while req1's word is packed after req0's word is pending → FSM in HOLD, all in_ready=0, out word 0 stable. Raising out_ready for one cycle → word 0 accepted, word 1 presented next edge with out_id=1.
- Mid-word gaps: req3 drops in_valid for 7 cycles after beat 2 while req0 is valid → grant stays on req3, in_ready[0]=0, word completes with req3's 4 beats in order.
- Reset mid-operation: rst_n=0 after 2 beats of req1 → next edge in_ready=0, out_valid=0. After release with all requesters valid, first grant goes to req0 and no stale lanes appear in its word.
